// File: rtl/cotm32_pkg.sv
// Shared types for the cotm32 load/store path: op kinds, fault codes, LSU bus states
// and small decode helpers used by the bus adapter.
package cotm32_pkg;

    localparam int XLEN       = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int LANES      = XLEN / BYTE_WIDTH;
    localparam int OFF_W      = $clog2(LANES);

    typedef enum logic [3:0] {
        LSU_NONE,
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsu_ls_t;

    typedef enum logic [1:0] {
        LSU_FAULT_NONE,
        LSU_FAULT_MISALIGNED,
        LSU_FAULT_TIMEOUT
    } lsu_fault_t;

    typedef enum logic [1:0] {
        LSU_ST_IDLE,
        LSU_ST_BUS,
        LSU_ST_RESP
    } lsu_state_t;

    function automatic logic lsu_is_store(lsu_ls_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_misaligned(lsu_ls_t op, logic [OFF_W-1:0] off);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return off[0];
            LSU_LW, LSU_SW:          return off != '0;
            default:                 return 1'b0;
        endcase
    endfunction

    // Byte enables are only ever non-zero for stores; loads read the whole word.
    function automatic logic [LANES-1:0] lsu_wstrb(lsu_ls_t op, logic [OFF_W-1:0] off);
        logic [LANES-1:0] one_b;
        logic [LANES-1:0] two_b;
        one_b    = '0;
        one_b[0] = 1'b1;
        two_b    = '0;
        two_b[1:0] = 2'b11;
        case (op)
            LSU_SB:  return one_b << off;
            LSU_SH:  return two_b << off;
            LSU_SW:  return '1;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: in store mode shifts LSB-aligned data up to its lane, in load
// mode shifts the addressed lane down and sign/zero-extends it.
module lsu_lane
    import cotm32_pkg::*;
#(
    parameter int XLEN = cotm32_pkg::XLEN
) (
    input  logic                                  store_mode_i,
    input  lsu_ls_t                               op_i,
    input  logic [$clog2(XLEN/BYTE_WIDTH)-1:0]    off_i,
    input  logic [XLEN-1:0]                       data_i,
    output logic [XLEN-1:0]                       data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        data_o  = '0;
        shifted = data_i >> {off_i, 3'b000};
        if (store_mode_i) begin
            case (op_i)
                LSU_SB:  data_o = {{(XLEN-8){1'b0}}, data_i[7:0]} << {off_i, 3'b000};
                LSU_SH:  data_o = {{(XLEN-16){1'b0}}, data_i[15:0]} << {off_i, 3'b000};
                LSU_SW:  data_o = data_i;
                default: data_o = '0;
            endcase
        end else begin
            case (op_i)
                LSU_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
                LSU_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
                LSU_LH:  data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                LSU_LHU: data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
                LSU_LW:  data_o = data_i;
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: accepts one core request at a time, runs a single
// word-aligned bus transfer with optional timeout, and returns an extended result.
module lsu_bus
    import cotm32_pkg::*;
#(
    parameter int          XLEN    = cotm32_pkg::XLEN,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  lsu_ls_t                      i_op,
    input  logic [XLEN-1:0]              i_addr,
    input  logic [XLEN-1:0]              i_wdata,
    output logic                         o_done,
    output logic [XLEN-1:0]              o_rdata,
    output lsu_fault_t                   o_fault,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [XLEN-1:0]              o_mem_addr,
    output logic [XLEN-1:0]              o_mem_wdata,
    output logic [XLEN/BYTE_WIDTH-1:0]   o_mem_wstrb,
    input  logic                         i_mem_ack,
    input  logic [XLEN-1:0]              i_mem_rdata
);

    localparam int OW = $clog2(XLEN / BYTE_WIDTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t      state_q, state_d;
    lsu_ls_t         op_q, op_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    lsu_fault_t      fault_q, fault_d;

    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;
    logic            timeout_hit;

    lsu_lane #(.XLEN(XLEN)) u_store_lane (
        .store_mode_i (1'b1),
        .op_i         (op_q),
        .off_i        (addr_q[OW-1:0]),
        .data_i       (wdata_q),
        .data_o       (st_data)
    );

    lsu_lane #(.XLEN(XLEN)) u_load_lane (
        .store_mode_i (1'b0),
        .op_i         (op_q),
        .off_i        (addr_q[OW-1:0]),
        .data_i       (i_mem_rdata),
        .data_o       (ld_data)
    );

    // The counter holds the number of ack-less BUS cycles already elapsed, so the
    // current cycle is the TIMEOUT-th one when cnt_q + 1 reaches TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (i_valid && (i_op != LSU_NONE)) begin
                    op_d    = i_op;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    cnt_d   = '0;
                    if (lsu_misaligned(i_op, i_addr[OW-1:0])) begin
                        state_d = LSU_ST_RESP;
                        fault_d = LSU_FAULT_MISALIGNED;
                        rdata_d = '0;
                    end else begin
                        state_d = LSU_ST_BUS;
                        req_d   = 1'b1;
                    end
                end
            end
            LSU_ST_BUS: begin
                // An ack in the final timeout cycle still completes normally.
                if (i_mem_ack) begin
                    state_d = LSU_ST_RESP;
                    req_d   = 1'b0;
                    fault_d = LSU_FAULT_NONE;
                    rdata_d = lsu_is_store(op_q) ? '0 : ld_data;
                end else if (timeout_hit) begin
                    state_d = LSU_ST_RESP;
                    req_d   = 1'b0;
                    fault_d = LSU_FAULT_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_ST_RESP: begin
                state_d = LSU_ST_IDLE;
            end
            default: begin
                state_d = LSU_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LSU_ST_IDLE;
            op_q    <= LSU_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            fault_q <= LSU_FAULT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign o_ready     = (state_q == LSU_ST_IDLE);
    assign o_done      = (state_q == LSU_ST_RESP);
    assign o_rdata     = rdata_q;
    assign o_fault     = fault_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = lsu_is_store(op_q);
    assign o_mem_addr  = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    assign o_mem_wdata = st_data;
    assign o_mem_wstrb = lsu_wstrb(op_q, addr_q[OW-1:0]);

endmodule

// File: tb/tb_lsu_bus.sv
// Randomized scoreboard bench for lsu_bus: a driver pushes modelled responses, a
// negedge monitor pops and compares them whenever the DUT completes or drives the bus.
module tb_lsu_bus;
    import cotm32_pkg::*;

    localparam int TMO = 16;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    lsu_ls_t     i_op;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_done;
    logic [31:0] o_rdata;
    lsu_fault_t  o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    lsu_bus #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_fault     (o_fault),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic [31:0] rdata;
        lsu_fault_t  fault;
        int          lat;
        int          req_cycles;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_wait = 0;
    logic [31:0] mem_word = '0;
    int          req_cnt = 0;
    int          req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from access size and lane offset, not from FSM structure.
    function automatic exp_t model(lsu_ls_t op, logic [31:0] addr, logic [31:0] wdata,
                                   logic [31:0] rdata, int waits);
        exp_t        e;
        int          size;
        int          off;
        bit          st;
        bit          sgn;
        logic [63:0] mask;
        logic [31:0] v;
        size = (op == LSU_LB || op == LSU_LBU || op == LSU_SB) ? 1 :
               (op == LSU_LH || op == LSU_LHU || op == LSU_SH) ? 2 : 4;
        st   = (op == LSU_SB || op == LSU_SH || op == LSU_SW);
        sgn  = (op == LSU_LB || op == LSU_LH);
        off  = int'(addr % 4);
        mask = (64'd1 << (8 * size)) - 64'd1;
        e.mem_addr  = addr & ~32'd3;
        e.we        = st;
        e.wstrb     = st ? 4'(((1 << size) - 1) << off) : 4'd0;
        e.mem_wdata = 32'((64'(wdata) & mask) << (8 * off));
        e.acc_cyc   = 0;
        e.rdata     = '0;
        if ((off % size) != 0) begin
            e.fault = LSU_FAULT_MISALIGNED;
            e.lat = 1;
            e.req_cycles = 0;
        end else if (waits >= TMO) begin
            e.fault = LSU_FAULT_TIMEOUT;
            e.lat = TMO + 1;
            e.req_cycles = TMO;
        end else begin
            e.fault = LSU_FAULT_NONE;
            e.lat = 2 + waits;
            e.req_cycles = waits + 1;
            if (!st) begin
                v = 32'((64'(rdata) >> (8 * off)) & mask);
                if (sgn && v[8 * size - 1]) v = v | ~32'(mask);
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Memory responder: acks after ack_wait request cycles; random acks while idle.
    always @(negedge clk) begin
        if (o_mem_req) begin
            if (req_cnt == ack_wait) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_word;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom;
            end
            req_cnt++;
        end else begin
            req_cnt     = 0;
            i_mem_ack   = ($urandom_range(0, 3) == 0);
            i_mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin : monitor
        bit   pending;
        exp_t e;
        if (!i_rst) begin
            pending = (exp_q.size() > 0) && (exp_q[0].acc_cyc < cyc);
            if (o_ready) req_seen = 0;
            if (!pending) begin
                chk("idle_ready", 32'(o_ready), 32'd1);
                chk("idle_done", 32'(o_done), 32'd0);
                chk("idle_req", 32'(o_mem_req), 32'd0);
            end else begin
                chk("busy_ready", 32'(o_ready), 32'd0);
                if (o_mem_req) begin
                    req_seen++;
                    chk("mem_addr", o_mem_addr, exp_q[0].mem_addr);
                    chk("mem_we", 32'(o_mem_we), 32'(exp_q[0].we));
                    chk("mem_wstrb", 32'(o_mem_wstrb), 32'(exp_q[0].wstrb));
                    if (exp_q[0].we) chk("mem_wdata", o_mem_wdata, exp_q[0].mem_wdata);
                end
                if (o_done) begin
                    e = exp_q.pop_front();
                    chk("fault", 32'(o_fault), 32'(e.fault));
                    chk("rdata", o_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    chk("req_cycles", 32'(req_seen), 32'(e.req_cycles));
                end
            end
        end
    end

    // Optionally idles with LSU_NONE while ready, then holds the request until taken.
    task automatic issue(input lsu_ls_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input int none_cycles);
        exp_t e;
        int   guard;
        for (int k = 0; k < none_cycles; k++) begin
            i_valid = 1'b1;
            i_op    = LSU_NONE;
            i_addr  = $urandom;
            i_wdata = $urandom;
            guard   = 0;
            while (!o_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
        end
        i_valid = 1'b1;
        i_op    = op;
        i_addr  = addr;
        i_wdata = wdata;
        guard   = 0;
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            chk("accept_wait", 32'(o_ready), 32'd1);
            return;
        end
        e = model(op, addr, wdata, rdata, waits);
        e.acc_cyc = cyc;
        ack_wait  = waits;
        mem_word  = rdata;
        exp_q.push_back(e);
        @(negedge clk);
        i_op    = LSU_NONE;
        i_valid = ($urandom_range(0, 1) == 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : driver
        int g;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_op    = LSU_NONE;
        i_addr  = '0;
        i_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_wstrb", 32'(o_mem_wstrb), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_fault", 32'(o_fault), 32'(LSU_FAULT_NONE));
        i_rst = 1'b0;
        @(negedge clk);

        issue(LSU_SB,  32'h103, 32'h12345678, 32'h0,        2,    0);
        issue(LSU_LH,  32'h202, 32'h0,        32'hffaabbcc, 1,    1);
        issue(LSU_LHU, 32'h202, 32'h0,        32'hffaabbcc, 3,    2);
        issue(LSU_LW,  32'h201, 32'h0,        32'h0,        0,    1);
        issue(LSU_SW,  32'h400, 32'hcafef00d, 32'h0,        1000, 0);
        issue(LSU_SW,  32'h404, 32'h01234567, 32'h0,        15,   0);
        issue(LSU_LW,  32'h408, 32'h0,        32'h89abcdef, 16,   0);
        issue(LSU_LB,  32'h40b, 32'h0,        32'h80112233, 0,    0);

        // Abort a transfer with reset mid-BUS: no completion may follow.
        issue(LSU_SW, 32'h300, 32'hdeadbeef, 32'h0, 1000, 0);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_req", 32'(o_mem_req), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        i_rst = 1'b0;
        @(negedge clk);
        issue(LSU_LBU, 32'h1, 32'h0, 32'h0000cc00, 1, 0);

        for (int n = 0; n < 40; n++) begin
            lsu_ls_t op;
            int      w;
            op = lsu_ls_t'($urandom_range(1, 8));
            w  = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 4);
            issue(op, $urandom, $urandom, $urandom, w, $urandom_range(0, 2));
        end

        g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
